// File: rtl/round_countdown_timer_if.sv
// Control pulses and status outputs of the per-round countdown timer.
// Pulses are single-cycle and sampled on the rising clock edge; status outputs are registered levels/pulses.
interface round_countdown_timer_if;
  logic       start;
  logic       pause_toggle;
  logic       add_time;
  logic [5:0] time_remaining;
  logic       running;
  logic       timeout;
  logic       expired;
  logic [1:0] dbg_state;

  modport master (
    output start, pause_toggle, add_time,
    input  time_remaining, running, timeout, expired, dbg_state
  );

  modport slave (
    input  start, pause_toggle, add_time,
    output time_remaining, running, timeout, expired, dbg_state
  );
endinterface

// File: rtl/round_countdown_timer.sv
// Round countdown: seconds-remaining counter driven by an internal prescaler,
// with pause, saturating bonus credit and restart. All outputs are registered.
module round_countdown_timer #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int START_SECONDS = 30,
  parameter int MAX_SECONDS   = 30,
  parameter int BONUS_SECONDS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  round_countdown_timer_if.slave bus
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0]      START_T    = 6'(START_SECONDS);
  localparam logic [6:0]      MAX_T      = 7'(MAX_SECONDS);
  localparam logic [6:0]      BONUS_T    = 7'(BONUS_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    time_q, time_d;
  logic          running_q, running_d;
  logic          timeout_q, timeout_d;
  logic          expired_q, expired_d;
  logic          tick;
  logic [6:0]    t_next;

  // Sum is formed in 7 bits so a credit near the top cannot wrap before clamping.
  function automatic logic [6:0] credit(input logic [6:0] t);
    logic [6:0] sum;
    sum = t + BONUS_T;
    return (sum > MAX_T) ? MAX_T : sum;
  endfunction

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    time_d    = time_q;
    timeout_d = 1'b0;
    tick      = 1'b0;
    t_next    = {1'b0, time_q};

    if (bus.start) begin
      state_d = RUN;
      presc_d = '0;
      time_d  = START_T;
    end else begin
      unique case (state_q)
        RUN: begin
          tick    = (presc_q == PRESC_LAST);
          presc_d = tick ? '0 : presc_q + PW'(1);
          // Decrement before crediting, so a bonus on the last tick rescues the round.
          if (tick)         t_next = t_next - 7'd1;
          if (bus.add_time) t_next = credit(t_next);
          time_d = t_next[5:0];
          if (t_next == 7'd0) begin
            state_d   = EXPIRED;
            timeout_d = 1'b1;
          end else if (bus.pause_toggle) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (bus.add_time) begin
            t_next = credit(t_next);
            time_d = t_next[5:0];
          end
          if (bus.pause_toggle) state_d = RUN;
        end
        default: ;
      endcase
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= START_T;
      running_q <= 1'b0;
      timeout_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      running_q <= running_d;
      timeout_q <= timeout_d;
      expired_q <= expired_d;
    end
  end

  assign bus.time_remaining = time_q;
  assign bus.running        = running_q;
  assign bus.timeout        = timeout_q;
  assign bus.expired        = expired_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_round_countdown_timer.sv
// Bench for round_countdown_timer: directed scenarios then random pulses,
// every cycle compared against a seconds/elapsed-cycles reference model.
module tb_round_countdown_timer;

  localparam int CLK_HZ = 10;
  localparam int START  = 30;
  localparam int MAXS   = 30;
  localparam int BONUS  = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic clk;
  logic rst_n;
  round_countdown_timer_if bus ();

  round_countdown_timer #(
    .CLK_HZ(CLK_HZ), .START_SECONDS(START), .MAX_SECONDS(MAXS), .BONUS_SECONDS(BONUS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int timeout_seen = 0;

  // ---------------- reference model ----------------
  int m_mode;
  int m_time;
  int m_elapsed;   // clk cycles spent running within the current second
  int m_timeout;

  task automatic model_reset();
    m_mode = M_IDLE; m_time = START; m_elapsed = 0; m_timeout = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit a);
    int t;
    m_timeout = 0;
    if (s) begin
      m_mode = M_RUN; m_time = START; m_elapsed = 0;
    end else if (m_mode == M_RUN) begin
      t = m_time;
      m_elapsed++;
      if (m_elapsed == CLK_HZ) begin
        m_elapsed = 0;
        t = t - 1;
      end
      if (a) t = (t + BONUS > MAXS) ? MAXS : t + BONUS;
      m_time = t;
      if (t == 0) begin
        m_mode = M_EXP; m_timeout = 1;
      end else if (p) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE) begin
      if (a) m_time = (m_time + BONUS > MAXS) ? MAXS : m_time + BONUS;
      if (p) m_mode = M_RUN;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".time"},    32'(bus.time_remaining), 32'(m_time));
    check({tag, ".running"}, 32'(bus.running),        32'(m_mode == M_RUN));
    check({tag, ".timeout"}, 32'(bus.timeout),        32'(m_timeout));
    check({tag, ".expired"}, 32'(bus.expired),        32'(m_mode == M_EXP));
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; drives pulses across one posedge, checks at the next negedge.
  task automatic step(input bit s, input bit p, input bit a);
    bus.start = s; bus.pause_toggle = p; bus.add_time = a;
    @(posedge clk);
    model_step(s, p, a);
    @(negedge clk);
    bus.start = 1'b0; bus.pause_toggle = 1'b0; bus.add_time = 1'b0;
    if (bus.timeout === 1'b1) timeout_seen++;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_time != target && n < 1000) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("run_to", 32'(bus.time_remaining), 32'(target));
  endtask

  task automatic run_to_expiry();
    int n = 0;
    while (m_mode != M_EXP && n < 1000) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("run_to_expiry", 32'(bus.expired), 32'd1);
  endtask

  // Asynchronous reset applied between clock edges, checked before any edge arrives.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    check_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause_toggle = 1'b0; bus.add_time = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(3);

    // 1: full round, 29 after one second, 0 after 30 with a single timeout pulse
    timeout_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    check("t1_start_time", 32'(bus.time_remaining), 32'd30);
    check("t1_start_running", 32'(bus.running), 32'd1);
    idle(9);
    check("t1_before_first_dec", 32'(bus.time_remaining), 32'd30);
    idle(1);
    check("t1_first_dec", 32'(bus.time_remaining), 32'd29);
    idle(290);
    check("t1_zero", 32'(bus.time_remaining), 32'd0);
    check("t1_timeout_at_zero", 32'(bus.timeout), 32'd1);
    check("t1_expired", 32'(bus.expired), 32'd1);
    check("t1_running", 32'(bus.running), 32'd0);
    idle(5);
    check("t1_timeout_count", 32'(timeout_seen), 32'd1);

    // 2: pause holds count and prescaler; resume finishes the partial second
    step(1'b1, 1'b0, 1'b0);
    idle(100);
    check("t2_at20", 32'(bus.time_remaining), 32'd20);
    k = $urandom_range(0, 8);
    idle(k);
    step(1'b0, 1'b1, 1'b0);
    idle(50);
    check("t2_paused_hold", 32'(bus.time_remaining), 32'd20);
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    while (bus.time_remaining == 6'd20 && n < 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("t2_resume_cycles", 32'(n), 32'(9 - k));
    check("t2_resume_value", 32'(bus.time_remaining), 32'd19);

    // 3: saturating and plain credit; ignored in IDLE and EXPIRED
    step(1'b1, 1'b0, 1'b0);
    run_to(28);
    step(1'b0, 1'b0, 1'b1);
    check("t3_sat", 32'(bus.time_remaining), 32'd30);
    run_to(12);
    step(1'b0, 1'b0, 1'b1);
    check("t3_plus5", 32'(bus.time_remaining), 32'd17);
    @(negedge clk);
    async_reset("t3_rst");
    step(1'b0, 1'b0, 1'b1);
    check("t3_idle_add", 32'(bus.time_remaining), 32'd30);
    step(1'b1, 1'b0, 1'b0);
    run_to_expiry();
    step(1'b0, 1'b1, 1'b1);
    check("t3_exp_add", 32'(bus.time_remaining), 32'd0);
    check("t3_exp_pause_ignored", 32'(bus.expired), 32'd1);

    // 4: credit on the final tick rescues the round
    step(1'b1, 1'b0, 1'b0);
    run_to(1);
    timeout_seen = 0;
    idle(CLK_HZ - 1);
    step(1'b0, 1'b0, 1'b1);
    check("t4_rescue_time", 32'(bus.time_remaining), 32'(BONUS));
    check("t4_rescue_running", 32'(bus.running), 32'd1);
    check("t4_no_timeout", 32'(timeout_seen), 32'd0);

    // 5: restart from EXPIRED and mid-round
    run_to_expiry();
    step(1'b1, 1'b0, 1'b0);
    check("t5_restart_time", 32'(bus.time_remaining), 32'd30);
    check("t5_restart_expired", 32'(bus.expired), 32'd0);
    check("t5_restart_running", 32'(bus.running), 32'd1);
    run_to(14);
    idle($urandom_range(1, 8));
    step(1'b1, 1'b0, 1'b0);
    check("t5_reload", 32'(bus.time_remaining), 32'd30);
    idle(9);
    check("t5_presc_cleared", 32'(bus.time_remaining), 32'd30);
    idle(1);
    check("t5_first_dec", 32'(bus.time_remaining), 32'd29);

    // 6: asynchronous reset mid-round
    run_to(7);
    idle($urandom_range(0, 8));
    timeout_seen = 0;
    async_reset("t6_rst");
    idle(3);
    check("t6_no_timeout", 32'(timeout_seen), 32'd0);

    // random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 24) == 0);
      if (m_mode == M_IDLE || m_mode == M_EXP) begin
        if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
